// File: rtl/vector_result_serializer_pkg.sv
// Shared FFT vector-unit definitions: custom-float sample format, lane geometry
// and a helper that pulls one lane out of a packed result vector.
package vector_result_serializer_pkg;

   localparam int EXP_WIDTH    = 4;
   localparam int SIG_WIDTH    = 4;
   localparam int FORMAT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
   localparam int VEC_LANES    = 4;
   localparam int LANE_W       = $clog2(VEC_LANES);
   localparam int VEC_WIDTH    = FORMAT_WIDTH * VEC_LANES;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VEC_LANES - 1);

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exponent;
      logic [SIG_WIDTH-1:0] significand;
   } cfloat_t;

   // Lane i lives at bits [i*FORMAT_WIDTH +: FORMAT_WIDTH].
   function automatic logic [FORMAT_WIDTH-1:0] lane_slice(
      input logic [VEC_WIDTH-1:0] vec,
      input logic [LANE_W-1:0]    idx
   );
      return vec[idx*FORMAT_WIDTH +: FORMAT_WIDTH];
   endfunction

endpackage

// File: rtl/vector_bank_pp.sv
// Two-bank ping-pong register file holding one complex 4-lane vector per bank,
// written whole and read one lane at a time.
module vector_bank_pp
   import vector_result_serializer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    wr_sel,
   input  logic [VEC_WIDTH-1:0]    wr_real,
   input  logic [VEC_WIDTH-1:0]    wr_imag,
   input  logic                    rd_sel,
   input  logic [LANE_W-1:0]       rd_lane,
   output logic [FORMAT_WIDTH-1:0] rd_real,
   output logic [FORMAT_WIDTH-1:0] rd_imag
);

   logic [1:0][VEC_WIDTH-1:0] bank_real;
   logic [1:0][VEC_WIDTH-1:0] bank_imag;

   // NOTE: the storage is small enough to reset; it keeps the read mux output
   // deterministic after reset and costs nothing in behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_real <= '0;
         bank_imag <= '0;
      end else if (wr_en) begin
         bank_real[wr_sel] <= wr_real;
         bank_imag[wr_sel] <= wr_imag;
      end
   end

   assign rd_real = lane_slice(bank_real[rd_sel], rd_lane);
   assign rd_imag = lane_slice(bank_imag[rd_sel], rd_lane);

endmodule

// File: rtl/vector_result_serializer.sv
// Captures 4-lane complex result vectors into a ping-pong buffer and streams
// them out one lane per cycle over valid/ready, flagging dropped vectors.
module vector_result_serializer
   import vector_result_serializer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    vector_done,
   input  logic [VEC_WIDTH-1:0]    vec_real,
   input  logic [VEC_WIDTH-1:0]    vec_imag,
   input  logic                    clear_ovf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [FORMAT_WIDTH-1:0] out_real,
   output logic [FORMAT_WIDTH-1:0] out_imag,
   output logic [LANE_W-1:0]       out_lane,
   output logic                    out_last,
   output logic                    busy,
   output logic                    full,
   output logic                    overflow
);

   logic [1:0]              count, count_next;
   logic                    wr_ptr, rd_ptr;
   logic [LANE_W-1:0]       lane;
   logic                    pop, last_pop, bank_free, capture, drop;
   logic [FORMAT_WIDTH-1:0] rd_real, rd_imag;

   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign last_pop  = pop && (lane == LAST_LANE);
   // A full buffer still accepts a vector when its oldest bank drains this cycle.
   assign bank_free = (count != 2'd2) || last_pop;
   assign capture   = vector_done && bank_free;
   assign drop      = vector_done && !bank_free;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      count_next = count;
      unique case ({capture, last_pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         lane     <= '0;
         overflow <= 1'b0;
      end else begin
         count <= count_next;
         if (capture)  wr_ptr <= ~wr_ptr;
         if (last_pop) rd_ptr <= ~rd_ptr;
         if (pop)      lane   <= lane + LANE_W'(1);
         if (drop)           overflow <= 1'b1;
         else if (clear_ovf) overflow <= 1'b0;
      end
   end

   vector_bank_pp u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (capture),
      .wr_sel  (wr_ptr),
      .wr_real (vec_real),
      .wr_imag (vec_imag),
      .rd_sel  (rd_ptr),
      .rd_lane (lane),
      .rd_real (rd_real),
      .rd_imag (rd_imag)
   );

   assign out_real = out_valid ? rd_real : '0;
   assign out_imag = out_valid ? rd_imag : '0;
   assign out_lane = lane;
   assign out_last = out_valid && (lane == LAST_LANE);
   assign full     = (count == 2'd2);
   assign busy     = out_valid;

endmodule

// File: tb/tb_vector_result_serializer.sv
// Directed bench for vector_result_serializer: streaming, back-pressure,
// full/drop, simultaneous capture and last pop, overflow clear, async reset.
module tb_vector_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        vector_done;
   logic [35:0] vec_real, vec_imag;
   logic        clear_ovf;
   logic        out_valid, out_ready;
   logic [8:0]  out_real, out_imag;
   logic [1:0]  out_lane;
   logic        out_last, busy, full, overflow;

   int total = 0;
   int bad   = 0;

   logic [8:0] vr [4][4];
   logic [8:0] vi [4][4];

   always #5 clk = ~clk;

   vector_result_serializer dut (
      .clk         (clk),
      .rst         (rst),
      .vector_done (vector_done),
      .vec_real    (vec_real),
      .vec_imag    (vec_imag),
      .clear_ovf   (clear_ovf),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_real    (out_real),
      .out_imag    (out_imag),
      .out_lane    (out_lane),
      .out_last    (out_last),
      .busy        (busy),
      .full        (full),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v);
      vec_real = {vr[v][3], vr[v][2], vr[v][1], vr[v][0]};
      vec_imag = {vi[v][3], vi[v][2], vi[v][1], vi[v][0]};
   endtask

   task automatic pulse(input int v);
      load(v);
      vector_done = 1'b1;
      tick();
      vector_done = 1'b0;
   endtask

   task automatic check_sample(input string tag, input int v, input int l);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_lane"},  32'(out_lane),  32'(l));
      check({tag, "_real"},  32'(out_real),  32'(vr[v][l]));
      check({tag, "_imag"},  32'(out_imag),  32'(vi[v][l]));
      check({tag, "_last"},  32'(out_last),  32'(l == 3));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_real"},  32'(out_real),  32'd0);
      check({tag, "_imag"},  32'(out_imag),  32'd0);
   endtask

   initial begin
      // Vector 0 from the plan; imag = real ^ 0x1FF, computed by hand.
      vr[0] = '{9'h101, 9'h0A2, 9'h1F3, 9'h004};
      vi[0] = '{9'h0FE, 9'h15D, 9'h00C, 9'h1FB};
      vr[1] = '{9'h011, 9'h022, 9'h033, 9'h044};
      vi[1] = '{9'h1AA, 9'h155, 9'h000, 9'h1FF};
      vr[2] = '{9'h0F0, 9'h00F, 9'h1E1, 9'h12C};
      vi[2] = '{9'h003, 9'h130, 9'h0C7, 9'h09A};
      vr[3] = '{9'h1C1, 9'h0D2, 9'h0E3, 9'h0F4};
      vi[3] = '{9'h015, 9'h026, 9'h037, 9'h048};

      rst = 1'b0; vector_done = 1'b0; clear_ovf = 1'b0; out_ready = 1'b0;
      vec_real = '0; vec_imag = '0;
      #12;
      check_idle("reset");
      check("reset_lane", 32'(out_lane), 32'd0);
      check("reset_full", 32'(full),     32'd0);
      check("reset_ovf",  32'(overflow), 32'd0);
      rst = 1'b1;
      tick();

      // Single vector with ready held high: four lanes then idle.
      out_ready = 1'b1;
      pulse(0);
      for (int l = 0; l < 4; l++) begin
         check_sample("single", 0, l);
         tick();
      end
      check_idle("single_end");

      // Back-pressure: pattern 1,0,0,1,1,0,1 gives exactly four handshakes.
      begin
         logic [6:0] pat;
         int exp_lane, hs;
         pat = 7'b1011001;
         exp_lane = 0;
         hs = 0;
         out_ready = 1'b0;
         pulse(1);
         for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            check_sample("bp", 1, exp_lane);
            if (out_valid && out_ready) hs++;
            tick();
            if (pat[i]) exp_lane++;
         end
         check("bp_handshakes", 32'(hs), 32'd4);
         check_idle("bp_end");
      end

      // Full and drop, with clear_ovf losing to a simultaneous drop.
      out_ready = 1'b0;
      pulse(0);
      check("fd_full_a", 32'(full), 32'd0);
      pulse(1);
      check("fd_full_b", 32'(full),     32'd1);
      check("fd_ovf_b",  32'(overflow), 32'd0);
      pulse(2);
      check("fd_ovf_c",  32'(overflow), 32'd1);
      check("fd_full_c", 32'(full),     32'd1);
      clear_ovf = 1'b0;
      tick();
      check("ovf_sticky", 32'(overflow), 32'd1);
      clear_ovf = 1'b1;
      pulse(3);
      check("ovf_set_wins", 32'(overflow), 32'd1);
      tick();
      clear_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_sample(i < 4 ? "drain_a" : "drain_b", i / 4, i % 4);
         tick();
      end
      check_idle("drain_end");

      // Capture on the same edge that pops lane 3 of the oldest bank.
      out_ready = 1'b0;
      pulse(2);
      pulse(1);
      check("sim_full_pre", 32'(full), 32'd1);
      out_ready = 1'b1;
      for (int l = 0; l < 3; l++) begin
         check_sample("sim_p", 2, l);
         tick();
      end
      check_sample("sim_p", 2, 3);
      pulse(3);
      check("sim_full_post", 32'(full),     32'd1);
      check("sim_ovf",       32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check_sample(i < 4 ? "sim_q" : "sim_d", i < 4 ? 1 : 3, i % 4);
         tick();
      end
      check_idle("sim_end");

      // Asynchronous reset while lane 2 is presented.
      out_ready = 1'b1;
      pulse(0);
      tick();
      tick();
      check_sample("pre_rst", 0, 2);
      #2 rst = 1'b0;
      #1;
      check_idle("async_rst");
      check("async_rst_lane", 32'(out_lane), 32'd0);
      check("async_rst_last", 32'(out_last), 32'd0);
      check("async_rst_full", 32'(full),     32'd0);
      #2 rst = 1'b1;
      tick();
      check_idle("post_rst");
      pulse(3);
      check_sample("post_rst_vec", 3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
